// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions for the pixel writer and the stream reader.
// Holds the default frame geometry, the pixel type and the reader FSM states.
package fb_pkg;

    localparam int H_RES     = 320;
    localparam int V_RES     = 180;
    localparam int FB_PIXELS = H_RES * V_RES;

    typedef logic [15:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

endpackage

// File: rtl/fb_stream_fifo.sv
// Small synchronous first-word-fall-through FIFO.
// The head entry is presented from register storage, so data_o, valid_o and
// count_o carry no combinational path from the push side.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_i/data_i  write one entry (caller guarantees no push while full)
//   pop_i          consume the head entry (ignored while empty)
//   valid_o/data_o head entry
//   count_o        current occupancy
module fb_stream_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_eff;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign pop_eff = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = push_i  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_eff ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_i && !pop_eff) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_eff) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage is cleared on reset so the stream outputs read as zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fb_stream_reader.sv
// Frame-buffer stream reader.
// On an accepted start it reads every pixel address in raster order from the
// BRAM spare port and delivers the pixels as a ready/valid stream with
// frame-start (first_out) and end-of-line (last_out) markers.
// Reads are only issued while the output FIFO is guaranteed to have room for
// every read already in flight, so backpressure never loses a returning pixel.
// Ports:
//   clk_in, rst_in            clock, asynchronous active-high reset
//   start_in                  one-cycle frame request (accepted only in IDLE)
//   busy_out, done_out        frame in progress / one-cycle completion pulse
//   rd_en_out, rd_addr_out    BRAM read request
//   rd_data_in                BRAM data, RD_LATENCY cycles after rd_en_out
//   valid_out, ready_in       output stream handshake
//   data_out, first_out, last_out  pixel and its markers
module fb_stream_reader #(
    parameter int H_RES      = fb_pkg::H_RES,
    parameter int V_RES      = fb_pkg::V_RES,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              rd_en_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    input  logic [DATA_W-1:0] rd_data_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              first_out,
    output logic              last_out
);

    import fb_pkg::*;

    localparam int XW  = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW  = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int CW  = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic                done_q, done_d;
    logic                rd_en;

    logic [RD_LATENCY-1:0] tag_vld_q, tag_first_q, tag_last_q;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         used;
    logic                  credit_ok;
    logic                  line_end, frame_end;

    logic                  fifo_push;
    logic                  fifo_valid;
    logic                  pop;
    logic [FCW-1:0]        fifo_count;
    logic [DATA_W+1:0]     fifo_rdata;

    assign line_end  = (x_q == XW'(H_RES - 1));
    assign frame_end = line_end && (y_q == YW'(V_RES - 1));
    assign pop       = fifo_valid && ready_in;
    assign fifo_push = tag_vld_q[RD_LATENCY-1];

    // A pop this cycle frees a slot, so it may be reused by this cycle's read.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(tag_vld_q[i]);
        end
        used      = CW'(fifo_count) + inflight - CW'(pop);
        credit_ok = (used < CW'(FIFO_DEPTH));
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                // done_q masks a start landing in the completion cycle.
                if (start_in && !done_q) begin
                    state_d = READ;
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            READ: begin
                if (credit_ok) begin
                    rd_en  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (line_end) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                    if (frame_end) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // With nothing in flight, the FIFO holds only the tail of the
                // frame; finish on the handshake that empties it.
                if (inflight == '0 &&
                    (fifo_count == '0 || (fifo_count == FCW'(1) && pop))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            done_q      <= 1'b0;
            tag_vld_q   <= '0;
            tag_first_q <= '0;
            tag_last_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
            // Tags ride alongside the BRAM latency so markers stay aligned.
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                tag_vld_q[i]   <= tag_vld_q[i-1];
                tag_first_q[i] <= tag_first_q[i-1];
                tag_last_q[i]  <= tag_last_q[i-1];
            end
            tag_vld_q[0]   <= rd_en;
            tag_first_q[0] <= (addr_q == '0);
            tag_last_q[0]  <= line_end;
        end
    end

    fb_stream_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (FCW)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .push_i  (fifo_push),
        .data_i  ({tag_first_q[RD_LATENCY-1], tag_last_q[RD_LATENCY-1], rd_data_in}),
        .pop_i   (pop),
        .valid_o (fifo_valid),
        .data_o  (fifo_rdata),
        .count_o (fifo_count)
    );

    assign busy_out    = (state_q != IDLE);
    assign done_out    = done_q;
    assign rd_en_out   = rd_en;
    assign rd_addr_out = addr_q;
    assign valid_out   = fifo_valid;
    assign first_out   = fifo_rdata[DATA_W+1];
    assign last_out    = fifo_rdata[DATA_W];
    assign data_out    = fifo_rdata[DATA_W-1:0];

endmodule

// File: tb/tb_fb_stream_reader.sv
// Bench for fb_stream_reader with a 4x3 frame, 2-cycle BRAM returning
// addr ^ 16'hA5A5, and a 4-entry output FIFO.
module tb_fb_stream_reader;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int N  = H * V;
    localparam int L  = 2;
    localparam int FD = 4;

    logic        clk;
    logic        rst_in;
    logic        start_in;
    logic        busy_out;
    logic        done_out;
    logic        rd_en_out;
    logic [15:0] rd_addr_out;
    logic [15:0] rd_data_in;
    logic        valid_out;
    logic        ready_in;
    logic [15:0] data_out;
    logic        first_out;
    logic        last_out;

    fb_stream_reader #(
        .H_RES      (H),
        .V_RES      (V),
        .ADDR_W     (16),
        .DATA_W     (16),
        .RD_LATENCY (L),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst_in),
        .start_in    (start_in),
        .busy_out    (busy_out),
        .done_out    (done_out),
        .rd_en_out   (rd_en_out),
        .rd_addr_out (rd_addr_out),
        .rd_data_in  (rd_data_in),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .data_out    (data_out),
        .first_out   (first_out),
        .last_out    (last_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: two-cycle read latency.
    logic [15:0] b1 = '0;
    logic [15:0] b2 = '0;
    always @(posedge clk) begin
        b1 <= rd_addr_out ^ 16'hA5A5;
        b2 <= b1;
    end
    assign rd_data_in = b2;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: queue of pixel addresses still owed to the consumer,
    // plus the read addresses still owed to the BRAM for the current frame.
    int          exp_q[$];
    int          reads_left = 0;
    int          reads_cnt  = 0;
    logic [15:0] exp_rd     = '0;
    int          done_cnt   = 0;
    logic        pend_done  = 1'b0;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_word  = '0;
    int          s0         = 0;
    int          rmode      = 0;

    // Compare process.
    always @(negedge clk) begin
        int          a;
        logic        np;
        logic [17:0] ew;
        if (rst_in) begin
            check("reset_outputs",
                  {busy_out, done_out, rd_en_out, valid_out, first_out, last_out,
                   rd_addr_out, data_out}, 64'h0);
            exp_q.delete();
            reads_left = 0;
            pend_done  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            np = 1'b0;
            check("no_push_when_full",
                  {63'h0, (dut.fifo_push && (int'(dut.fifo_count) == FD))}, 64'h0);
            check("done_timing", {63'h0, done_out}, {63'h0, pend_done});
            if (done_out) done_cnt++;
            if (pend_done) check("busy_low_at_done", {63'h0, busy_out}, 64'h0);
            if (prev_stall)
                check("hold_stable", {valid_out, first_out, last_out, data_out},
                      {1'b1, prev_word});
            if (rd_en_out) begin
                check("rd_addr", {reads_left > 0, rd_addr_out}, {1'b1, exp_rd});
                exp_rd = exp_rd + 16'd1;
                reads_left--;
                reads_cnt++;
            end
            if (valid_out && ready_in) begin
                check("pixel_owed", {63'h0, exp_q.size() != 0}, 64'h1);
                if (exp_q.size() != 0) begin
                    a  = exp_q.pop_front();
                    ew = {a == 0, (a % H) == H - 1, 16'(a) ^ 16'hA5A5};
                    check("pixel", {first_out, last_out, data_out}, ew);
                    np = (a == N - 1);
                end
            end
            pend_done  = np;
            prev_stall = valid_out && !ready_in;
            prev_word  = {first_out, last_out, data_out};
        end
    end

    // Ready pattern generator.
    initial begin
        ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0:       ready_in = 1'b1;
                1:       ready_in = ~ready_in;
                default: ready_in = 1'b0;
            endcase
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Marks the current cycle as cycle 0 of a frame the DUT will accept.
    task automatic arm_frame();
        for (int i = 0; i < N; i++) exp_q.push_back(i);
        reads_left = N;
        reads_cnt  = 0;
        exp_rd     = '0;
        s0         = cyc;
    endtask

    task automatic wait_cycle(input int n);
        while (cyc - s0 < n) next_cycle();
        @(negedge clk);
    endtask

    task automatic wait_done(input int target, input int limit);
        int n = 0;
        while (done_cnt < target && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_reached", {63'h0, done_cnt >= target}, 64'h1);
    endtask

    task automatic start_frame();
        next_cycle();
        start_in = 1'b1;
        arm_frame();
        next_cycle();
        start_in = 1'b0;
    endtask

    initial begin
        rst_in   = 1'b1;
        start_in = 1'b0;
        repeat (3) next_cycle();
        rst_in = 1'b0;
        next_cycle();

        // Single frame, ready held high.
        rmode = 0;
        start_frame();
        wait_cycle(1);
        check("t1_c1_read", {busy_out, rd_en_out, rd_addr_out}, {1'b1, 1'b1, 16'h0000});
        wait_cycle(3);
        check("t1_c3_empty", {63'h0, valid_out}, 64'h0);
        wait_cycle(4);
        check("t1_c4_first", {valid_out, first_out, last_out, data_out},
              {1'b1, 1'b1, 1'b0, 16'hA5A5});
        wait_cycle(7);
        check("t1_c7_eol", {valid_out, first_out, last_out, data_out},
              {1'b1, 1'b0, 1'b1, 16'hA5A6});
        wait_cycle(15);
        check("t1_c15_lastpix", {valid_out, first_out, last_out, data_out},
              {1'b1, 1'b0, 1'b1, 16'hA5AE});
        wait_cycle(16);
        check("t1_c16_done", {done_out, busy_out}, {1'b1, 1'b0});
        check("t1_all_out", exp_q.size(), 0);

        // Ready toggling every cycle.
        rmode = 1;
        start_frame();
        wait_done(2, 300);
        check("t2_all_out", exp_q.size(), 0);

        // Ready held low: exactly four reads, head pixel held.
        rmode = 2;
        next_cycle();
        start_frame();
        wait_cycle(20);
        check("t3_reads", reads_cnt, 4);
        check("t3_hold", {valid_out, first_out, data_out}, {1'b1, 1'b1, 16'hA5A5});
        rmode = 0;
        wait_done(3, 300);
        check("t3_all_out", exp_q.size(), 0);

        // Second start mid-frame is ignored.
        start_frame();
        wait_cycle(5);
        next_cycle();
        start_in = 1'b1;
        next_cycle();
        start_in = 1'b0;
        wait_done(4, 300);
        repeat (6) next_cycle();
        check("t4_single_done", done_cnt, 4);
        check("t4_reads", reads_cnt, N);
        check("t4_all_out", exp_q.size(), 0);

        // Reset mid-frame, then a clean frame.
        start_frame();
        wait_cycle(7);
        next_cycle();
        rst_in = 1'b1;
        next_cycle();
        next_cycle();
        rst_in = 1'b0;
        start_frame();
        wait_cycle(4);
        check("t5_first_after_rst", {valid_out, first_out, last_out, data_out},
              {1'b1, 1'b1, 1'b0, 16'hA5A5});
        wait_done(5, 300);
        check("t5_all_out", exp_q.size(), 0);

        // Back-to-back: start in the done cycle ignored, next cycle accepted.
        start_frame();
        wait_cycle(15);
        next_cycle();
        start_in = 1'b1;
        next_cycle();
        arm_frame();
        next_cycle();
        start_in = 1'b0;
        wait_cycle(4);
        check("t6_second_first", {valid_out, first_out, last_out, data_out},
              {1'b1, 1'b1, 1'b0, 16'hA5A5});
        wait_cycle(16);
        check("t6_second_done", {done_out, busy_out}, {1'b1, 1'b0});
        wait_done(7, 300);
        check("t6_all_out", exp_q.size(), 0);

        repeat (3) next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
